// File: rtl/fmc_pkg.sv
// Shared types and constants for the muxed FMC bus initiator.
// Holds the phase enum, default timings, channel map and counter width.
package fmc_pkg;

    localparam int CNT_W = 8;

    localparam int unsigned DEF_ADDSET  = 2;
    localparam int unsigned DEF_ADDHLD  = 1;
    localparam int unsigned DEF_DATAST  = 4;
    localparam int unsigned DEF_BUSTURN = 2;

    // Register channels decoded by the FPGA-side slave.
    localparam int          CH_NUM  = 16;
    localparam logic [15:0] CH_BASE = 16'h0000;
    localparam logic [15:0] CH_LAST = CH_BASE + 16'(CH_NUM - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_AHOLD,
        S_DATA,
        S_HOLD,
        S_TURN
    } state_t;

    // Counter preload for a phase lasting len cycles.
    function automatic logic [CNT_W-1:0] phase_ld(input int unsigned len);
        return CNT_W'(len - 1);
    endfunction

endpackage

// File: rtl/fmc_phase_cnt.sv
// Loadable down-counter that times each bus phase.
// Ports: clk_i, rst_ni (async low), load_i/load_val_i preload, zero_o flag.
module fmc_phase_cnt
    import fmc_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fmc_master.sv
// Initiator for the 16-bit multiplexed FMC bus (NE1/NADV/NWE/NOE).
// Ports: clk, rst (async low), req_* valid/ready request, done/rdata
// completion, fpga_* strobes (active-low) and fpga_db shared A/D bus.
module fmc_master
    import fmc_pkg::*;
#(
    parameter int unsigned ADDSET  = DEF_ADDSET,
    parameter int unsigned ADDHLD  = DEF_ADDHLD,
    parameter int unsigned DATAST  = DEF_DATAST,
    parameter int unsigned BUSTURN = DEF_BUSTURN
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        done,
    output logic [15:0] rdata,
    output logic        fpga_cs_ne1,
    output logic        fpga_nl_nadv,
    output logic        fpga_wr_nwe,
    output logic        fpga_rd_noe,
    inout  wire  [15:0] fpga_db
);

    localparam logic [CNT_W-1:0] LD_ADDR  = phase_ld(ADDSET);
    localparam logic [CNT_W-1:0] LD_AHOLD = phase_ld(ADDHLD);
    localparam logic [CNT_W-1:0] LD_DATA  = phase_ld(DATAST);
    localparam logic [CNT_W-1:0] LD_HOLD  = phase_ld(1);
    localparam logic [CNT_W-1:0] LD_TURN  = phase_ld(BUSTURN);

    state_t state_q, state_d;

    logic             ld;
    logic [CNT_W-1:0] ld_val;
    logic             cnt_zero;
    logic             accept;

    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic [15:0] rdata_q, rdata_d;
    logic [15:0] dout_q, dout_d;
    logic        oe_q, oe_d;
    logic        ne1_q, ne1_d;
    logic        nadv_q, nadv_d;
    logic        nwe_q, nwe_d;
    logic        noe_q, noe_d;
    logic        done_q, done_d;

    fmc_phase_cnt u_cnt (
        .clk_i      (clk),
        .rst_ni     (rst),
        .load_i     (ld),
        .load_val_i (ld_val),
        .zero_o     (cnt_zero)
    );

    assign accept = req_valid && (state_q == S_IDLE);

    always_comb begin
        state_d = state_q;
        ld      = 1'b0;
        ld_val  = '0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_ADDR;
                    ld      = 1'b1;
                    ld_val  = LD_ADDR;
                end
            end
            S_ADDR: begin
                if (cnt_zero) begin
                    state_d = S_AHOLD;
                    ld      = 1'b1;
                    ld_val  = LD_AHOLD;
                end
            end
            S_AHOLD: begin
                if (cnt_zero) begin
                    state_d = S_DATA;
                    ld      = 1'b1;
                    ld_val  = LD_DATA;
                end
            end
            S_DATA: begin
                if (cnt_zero) begin
                    state_d = S_HOLD;
                    ld      = 1'b1;
                    ld_val  = LD_HOLD;
                end
            end
            S_HOLD: begin
                if (cnt_zero) begin
                    state_d = S_TURN;
                    ld      = 1'b1;
                    ld_val  = LD_TURN;
                end
            end
            S_TURN: begin
                if (cnt_zero) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Strobes and bus enable are decoded from the next state and
    // registered, so they change cleanly on the edge that enters a phase.
    always_comb begin
        addr_d  = accept ? req_addr : addr_q;
        wdata_d = accept ? req_wdata : wdata_q;
        wr_d    = accept ? req_write : wr_q;

        ne1_d  = (state_d == S_IDLE) || (state_d == S_TURN);
        nadv_d = (state_d != S_ADDR);
        nwe_d  = !((state_d == S_DATA) && wr_d);
        noe_d  = !((state_d == S_DATA) && !wr_d);
        done_d = (state_d == S_HOLD);

        oe_d = (state_d == S_ADDR) || (state_d == S_AHOLD)
            || (((state_d == S_DATA) || (state_d == S_HOLD)) && wr_d);

        dout_d = ((state_d == S_ADDR) || (state_d == S_AHOLD))
            ? addr_d : wdata_d;

        // Read data is captured on the edge closing the last DATA cycle.
        rdata_d = rdata_q;
        if ((state_q == S_DATA) && cnt_zero && !wr_q) begin
            rdata_d = fpga_db;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            dout_q  <= '0;
            oe_q    <= 1'b0;
            ne1_q   <= 1'b1;
            nadv_q  <= 1'b1;
            nwe_q   <= 1'b1;
            noe_q   <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            dout_q  <= dout_d;
            oe_q    <= oe_d;
            ne1_q   <= ne1_d;
            nadv_q  <= nadv_d;
            nwe_q   <= nwe_d;
            noe_q   <= noe_d;
            done_q  <= done_d;
        end
    end

    assign req_ready    = (state_q == S_IDLE);
    assign done         = done_q;
    assign rdata        = rdata_q;
    assign fpga_cs_ne1  = ne1_q;
    assign fpga_nl_nadv = nadv_q;
    assign fpga_wr_nwe  = nwe_q;
    assign fpga_rd_noe  = noe_q;
    assign fpga_db      = oe_q ? dout_q : 16'hzzzz;

endmodule

// File: tb/tb_fmc_master.sv
// Bench for fmc_master: default-timing and all-ones-timing instances.
// A cycle-index model predicts every output; directed flows pin it.
module tb_fmc_master;

    localparam int P_AS [2] = '{2, 1};
    localparam int P_AH [2] = '{1, 1};
    localparam int P_DS [2] = '{4, 1};
    localparam int P_BT [2] = '{2, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        vld  [2];
    logic        wr   [2];
    logic [15:0] ad   [2];
    logic [15:0] wd   [2];
    logic [15:0] sv   [2];
    logic        rdy  [2];
    logic        dn   [2];
    logic [15:0] rdat [2];
    logic        ne1  [2];
    logic        nadv [2];
    logic        nwe  [2];
    logic        noe  [2];
    wire  [15:0] db0;
    wire  [15:0] db1;
    logic [15:0] dbv  [2];

    int checks = 0;
    int errors = 0;

    // Slave model: answers reads while NOE is low and parks the bus
    // at 0x0000 while NE1 is high, so any stray DUT drive shows up.
    assign db0 = !noe[0] ? sv[0] : (ne1[0] ? 16'h0000 : 16'hzzzz);
    assign db1 = !noe[1] ? sv[1] : (ne1[1] ? 16'h0000 : 16'hzzzz);
    assign dbv[0] = db0;
    assign dbv[1] = db1;

    fmc_master #(
        .ADDSET(2), .ADDHLD(1), .DATAST(4), .BUSTURN(2)
    ) u_dut0 (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (vld[0]),
        .req_ready    (rdy[0]),
        .req_write    (wr[0]),
        .req_addr     (ad[0]),
        .req_wdata    (wd[0]),
        .done         (dn[0]),
        .rdata        (rdat[0]),
        .fpga_cs_ne1  (ne1[0]),
        .fpga_nl_nadv (nadv[0]),
        .fpga_wr_nwe  (nwe[0]),
        .fpga_rd_noe  (noe[0]),
        .fpga_db      (db0)
    );

    fmc_master #(
        .ADDSET(1), .ADDHLD(1), .DATAST(1), .BUSTURN(1)
    ) u_dut1 (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (vld[1]),
        .req_ready    (rdy[1]),
        .req_write    (wr[1]),
        .req_addr     (ad[1]),
        .req_wdata    (wd[1]),
        .done         (dn[1]),
        .rdata        (rdat[1]),
        .fpga_cs_ne1  (ne1[1]),
        .fpga_nl_nadv (nadv[1]),
        .fpga_wr_nwe  (nwe[1]),
        .fpga_rd_noe  (noe[1]),
        .fpga_db      (db1)
    );

    task automatic chk16(input string nm, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chkb(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b", nm, act, exp);
        end
    endtask

    task automatic chki(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int tlen(input int i);
        return P_AS[i] + P_AH[i] + P_DS[i] + 1 + P_BT[i];
    endfunction

    // Phase of cycle k after accept: 1 addr, 2 addr hold,
    // 3 data strobe, 4 hold/done, 5 turnaround, 0 idle.
    function automatic int phase(input int i, input int k);
        int a;
        a = P_AS[i];
        if (k < 1) return 0;
        if (k <= a) return 1;
        a += P_AH[i];
        if (k <= a) return 2;
        a += P_DS[i];
        if (k <= a) return 3;
        a += 1;
        if (k <= a) return 4;
        if (k <= tlen(i)) return 5;
        return 0;
    endfunction

    logic        mbusy [2];
    int          mk    [2];
    logic        mw    [2];
    logic [15:0] ma    [2];
    logic [15:0] mwd   [2];
    logic [15:0] mpend [2];
    logic [15:0] erd   [2];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                mbusy[i] <= 1'b0;
                mk[i]    <= 0;
                erd[i]   <= 16'h0000;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (mbusy[i]) begin
                    if (mk[i] == P_AS[i] + P_AH[i] + P_DS[i] && !mw[i])
                        erd[i] <= mpend[i];
                    if (mk[i] == tlen(i))
                        mbusy[i] <= 1'b0;
                    mk[i] <= mk[i] + 1;
                end else if (vld[i]) begin
                    mbusy[i] <= 1'b1;
                    mk[i]    <= 1;
                    mw[i]    <= wr[i];
                    ma[i]    <= ad[i];
                    mwd[i]   <= wd[i];
                    mpend[i] <= sv[i];
                end
            end
        end
    end

    // One compare process, every cycle, both instances.
    always @(negedge clk) begin
        int ph;
        logic [15:0] eb;
        logic bad;
        for (int i = 0; i < 2; i++) begin
            ph = (rst === 1'b1 && mbusy[i] === 1'b1) ? phase(i, mk[i]) : 0;
            chkb($sformatf("u%0d ne1", i), ne1[i], !(ph >= 1 && ph <= 4));
            chkb($sformatf("u%0d nadv", i), nadv[i], ph != 1);
            chkb($sformatf("u%0d nwe", i), nwe[i], !(ph == 3 && mw[i]));
            chkb($sformatf("u%0d noe", i), noe[i], !(ph == 3 && !mw[i]));
            chkb($sformatf("u%0d done", i), dn[i], ph == 4);
            chkb($sformatf("u%0d ready", i), rdy[i], ph == 0);
            chk16($sformatf("u%0d rdata", i), rdat[i],
                  (rst === 1'b1) ? erd[i] : 16'h0000);
            if (!(ph == 4 && !mw[i])) begin
                if (ph == 1 || ph == 2) eb = ma[i];
                else if (ph == 3 && !mw[i]) eb = mpend[i];
                else if (ph == 3 || ph == 4) eb = mwd[i];
                else eb = 16'h0000;
                chk16($sformatf("u%0d bus", i), dbv[i], eb);
            end
            bad = (!nwe[i] && !noe[i]) || ((!nwe[i] || !noe[i]) && !nadv[i]);
            chkb($sformatf("u%0d strobe_excl", i), bad, 1'b0);
        end
    end

    // ---------------- directed flows ----------------
    task automatic txn(input int i, input logic w, input logic [15:0] a,
                       input logic [15:0] d, input logic [15:0] s,
                       output int dk, output int nadv_n,
                       output int nwe_n, output int noe_n,
                       output int turn_n, output int len,
                       output logic [15:0] rd, output logic [15:0] abus,
                       output logic [15:0] dbus);
        logic seen;
        dk = 0; nadv_n = 0; nwe_n = 0; noe_n = 0; turn_n = 0; len = 0;
        rd = '0; abus = '0; dbus = '0; seen = 1'b0;
        @(posedge clk); #1;
        vld[i] = 1'b1; wr[i] = w; ad[i] = a; wd[i] = d; sv[i] = s;
        @(posedge clk); #1;
        vld[i] = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (rdy[i]) begin
                len = c - 1;
                break;
            end
            if (c == 1) abus = dbv[i];
            if (!nadv[i]) nadv_n++;
            if (!nwe[i]) nwe_n++;
            if (!noe[i]) noe_n++;
            if ((!nwe[i] || !noe[i]) && !seen) begin
                dbus = dbv[i];
                seen = 1'b1;
            end
            if (dk != 0 && ne1[i]) turn_n++;
            if (dn[i]) begin
                dk = c;
                rd = rdat[i];
            end
        end
    endtask

    task automatic wait_idle(input int i);
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (rdy[i]) return;
        end
        chkb("wait_idle timeout", 1'b0, 1'b1);
    endtask

    int dk, nn, nw, no, tn, ln, first, nd, got;
    logic [15:0] rd, ab, dbs, rv, lastaddr;

    initial begin
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            vld[i] = 1'b0; wr[i] = 1'b0; ad[i] = '0; wd[i] = '0; sv[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        chkb("reset ready", rdy[0], 1'b1);
        chkb("reset done", dn[0], 1'b0);
        chk16("reset rdata", rdat[0], 16'h0000);
        chkb("reset ne1", ne1[0], 1'b1);
        chk16("reset bus", db0, 16'h0000);
        rst = 1'b1;

        // Write 0x0003 <- 0xA5A5, default timing.
        txn(0, 1'b1, 16'h0003, 16'hA5A5, 16'h0000,
            dk, nn, nw, no, tn, ln, rd, ab, dbs);
        chki("wr done_cycle", dk, 8);
        chki("wr nadv_low", nn, 2);
        chki("wr nwe_low", nw, 4);
        chki("wr noe_low", no, 0);
        chki("wr turn_cycles", tn, 2);
        chki("wr length", ln, 10);
        chk16("wr addr_bus", ab, 16'h0003);
        chk16("wr data_bus", dbs, 16'hA5A5);

        // Read 0x0005, slave returns 0x1234.
        txn(0, 1'b0, 16'h0005, 16'h4C4C, 16'h1234,
            dk, nn, nw, no, tn, ln, rd, ab, dbs);
        chki("rd done_cycle", dk, 8);
        chki("rd noe_low", no, 4);
        chki("rd nwe_low", nw, 0);
        chki("rd length", ln, 10);
        chk16("rd addr_bus", ab, 16'h0005);
        chk16("rd data_bus", dbs, 16'h1234);
        chk16("rd rdata_at_done", rd, 16'h1234);
        chk16("rd rdata_held", rdat[0], 16'h1234);

        // Back-to-back write then read with valid held high.
        @(posedge clk); #1;
        vld[0] = 1'b1; wr[0] = 1'b1; ad[0] = 16'h0007;
        wd[0] = 16'h5A5A; sv[0] = 16'hBEEF;
        @(posedge clk); #1;
        wr[0] = 1'b0; ad[0] = 16'h0008; wd[0] = 16'h0000;
        first = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (rdy[0]) begin
                first = c;
                break;
            end
        end
        @(posedge clk); #1;
        vld[0] = 1'b0;
        chki("b2b first_idle_cycle", first, 11);
        chkb("b2b busy_after_accept", rdy[0], 1'b0);
        got = 0; rv = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (dn[0]) begin
                got = 1;
                rv = rdat[0];
                break;
            end
        end
        chki("b2b read_done", got, 1);
        chk16("b2b rdata", rv, 16'hBEEF);

        // Request raised mid-transaction: serviced once, after idle.
        wait_idle(0);
        @(posedge clk); #1;
        vld[0] = 1'b1; wr[0] = 1'b1; ad[0] = 16'h0001; wd[0] = 16'h1111;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vld[0] = 1'b1; ad[0] = 16'h000F; wd[0] = 16'hF00F;
        nd = 0; lastaddr = '0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (dn[0]) nd++;
            if (!nadv[0]) lastaddr = db0;
            if (rdy[0] && vld[0]) begin
                @(posedge clk); #1;
                vld[0] = 1'b0;
            end
        end
        chki("mid done_count", nd, 2);
        chk16("mid second_addr", lastaddr, 16'h000F);

        // Reset in the 2nd DATA cycle of a write.
        wait_idle(0);
        @(posedge clk); #1;
        vld[0] = 1'b1; wr[0] = 1'b1; ad[0] = 16'h0002; wd[0] = 16'h7E7E;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chkb("rst pre nwe_low", nwe[0], 1'b0);
        chk16("rst pre rdata", rdat[0], 16'hBEEF);
        #1;
        rst = 1'b0;
        #1;
        chkb("rst async nwe", nwe[0], 1'b1);
        chkb("rst async ne1", ne1[0], 1'b1);
        chkb("rst async noe", noe[0], 1'b1);
        chkb("rst async nadv", nadv[0], 1'b1);
        chk16("rst async bus", db0, 16'h0000);
        chkb("rst async done", dn[0], 1'b0);
        chk16("rst async rdata", rdat[0], 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        nd = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (dn[0]) nd++;
        end
        chki("rst no_done", nd, 0);
        txn(0, 1'b1, 16'h0009, 16'h3333, 16'h0000,
            dk, nn, nw, no, tn, ln, rd, ab, dbs);
        chki("post_rst done_cycle", dk, 8);
        chki("post_rst length", ln, 10);
        chk16("post_rst data_bus", dbs, 16'h3333);

        // Minimum timing instance: read 0x0000.
        txn(1, 1'b0, 16'h0000, 16'h9999, 16'h3C3C,
            dk, nn, nw, no, tn, ln, rd, ab, dbs);
        chki("min length", ln, 5);
        chki("min done_cycle", dk, 4);
        chki("min nadv_low", nn, 1);
        chki("min noe_low", no, 1);
        chki("min turn_cycles", tn, 1);
        chk16("min rdata", rd, 16'h3C3C);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule
